// File: rtl/change_dispenser.sv
// change_dispenser: pays vending credit back as dollar and quarter coins.
// Latches the credit on a refund request, tells the core to clear it, then
// ejects one coin at a time (largest first), waiting for the drop sensor to
// confirm each coin before choosing the next. A missing confirmation parks
// the block in FAULT until fault_clr_i.
module change_dispenser #(
    parameter int CREDIT_W      = 12,
    parameter int DOLLAR_CENTS  = 100,
    parameter int QUARTER_CENTS = 25,
    parameter int PULSE_CYCLES  = 4,
    parameter int ACK_TIMEOUT   = 255,
    parameter int HOPPER_W      = 6,
    parameter int HOPPER_INIT   = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                refund_req_i,
    input  logic [CREDIT_W-1:0] credit_in_i,
    input  logic                coin_sensed_i,
    input  logic                refill_dollar_i,
    input  logic                refill_quarter_i,
    input  logic                fault_clr_i,
    output logic                credit_clr_o,
    output logic                eject_dollar_o,
    output logic                eject_quarter_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [CREDIT_W-1:0] unpaid_o,
    output logic [1:0]          hopper_empty_o,
    output logic                fault_o
);

    // One counter serves both the eject pulse length and the ack timeout.
    localparam int CNT_MAX = (ACK_TIMEOUT > PULSE_CYCLES) ? ACK_TIMEOUT : PULSE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CREDIT_W-1:0] DOLLAR_V   = CREDIT_W'(DOLLAR_CENTS);
    localparam logic [CREDIT_W-1:0] QUARTER_V  = CREDIT_W'(QUARTER_CENTS);
    localparam logic [HOPPER_W-1:0] HOP_FULL   = {HOPPER_W{1'b1}};
    localparam logic [HOPPER_W-1:0] HOP_INIT   = HOPPER_W'(HOPPER_INIT);
    localparam logic [CNT_W-1:0]    PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_EJECT  = 3'd2,
        S_WAIT   = 3'd3,
        S_FINISH = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t              state_q;
    logic [CREDIT_W-1:0] rem_q;
    logic [HOPPER_W-1:0] dollars_q;
    logic [HOPPER_W-1:0] quarters_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                sel_dollar_q;
    logic                req_prev_q;
    logic                sensed_prev_q;
    logic                credit_clr_q;
    logic                eject_dollar_q;
    logic                eject_quarter_q;
    logic                busy_q;
    logic                done_q;
    logic [CREDIT_W-1:0] unpaid_q;
    logic [1:0]          hopper_empty_q;
    logic                fault_q;

    logic req_rise_d;
    logic sensed_rise_d;

    // Hopper count minus one coin, held at zero.
    function automatic logic [HOPPER_W-1:0] sat_dec(input logic [HOPPER_W-1:0] cnt);
        if (cnt == '0) begin
            return cnt;
        end else begin
            return cnt - HOPPER_W'(1);
        end
    endfunction

    assign req_rise_d    = refund_req_i  & ~req_prev_q;
    assign sensed_rise_d = coin_sensed_i & ~sensed_prev_q;

    // Previous-cycle copies of the request and sensor for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_prev_q    <= 1'b0;
            sensed_prev_q <= 1'b0;
        end else begin
            req_prev_q    <= refund_req_i;
            sensed_prev_q <= coin_sensed_i;
        end
    end

    // Empty flags lag the hopper counts by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hopper_empty_q <= 2'b00;
        end else begin
            hopper_empty_q <= {(dollars_q == '0), (quarters_q == '0)};
        end
    end

    // Refund sequencer with hoppers and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rem_q           <= '0;
            dollars_q       <= HOP_INIT;
            quarters_q      <= HOP_INIT;
            cnt_q           <= '0;
            sel_dollar_q    <= 1'b0;
            credit_clr_q    <= 1'b0;
            eject_dollar_q  <= 1'b0;
            eject_quarter_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            unpaid_q        <= '0;
            fault_q         <= 1'b0;
        end else begin
            credit_clr_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Refills only land here; a same-cycle request sees them in SELECT.
                    if (refill_dollar_i) begin
                        dollars_q <= HOP_FULL;
                    end
                    if (refill_quarter_i) begin
                        quarters_q <= HOP_FULL;
                    end
                    if (req_rise_d) begin
                        if (credit_in_i != '0) begin
                            rem_q        <= credit_in_i;
                            credit_clr_q <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= S_SELECT;
                        end else begin
                            done_q   <= 1'b1;
                            unpaid_q <= '0;
                        end
                    end
                end
                S_SELECT: begin
                    // Quarters stand in for dollars when the dollar hopper is dry.
                    if ((rem_q >= DOLLAR_V) && (dollars_q != '0)) begin
                        sel_dollar_q   <= 1'b1;
                        eject_dollar_q <= 1'b1;
                        cnt_q          <= PULSE_LAST;
                        state_q        <= S_EJECT;
                    end else if ((rem_q >= QUARTER_V) && (quarters_q != '0)) begin
                        sel_dollar_q    <= 1'b0;
                        eject_quarter_q <= 1'b1;
                        cnt_q           <= PULSE_LAST;
                        state_q         <= S_EJECT;
                    end else begin
                        state_q <= S_FINISH;
                    end
                end
                S_EJECT: begin
                    if (cnt_q == '0) begin
                        eject_dollar_q  <= 1'b0;
                        eject_quarter_q <= 1'b0;
                        state_q         <= S_WAIT;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    // cnt_q restarts from zero on entry (EJECT leaves it there).
                    if (sensed_rise_d) begin
                        if (sel_dollar_q) begin
                            dollars_q <= sat_dec(dollars_q);
                            rem_q     <= rem_q - DOLLAR_V;
                        end else begin
                            quarters_q <= sat_dec(quarters_q);
                            rem_q      <= rem_q - QUARTER_V;
                        end
                        state_q <= S_SELECT;
                    end else if (cnt_q == ACK_LAST) begin
                        unpaid_q <= rem_q;
                        fault_q  <= 1'b1;
                        state_q  <= S_FAULT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    unpaid_q <= rem_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                S_FAULT: begin
                    if (fault_clr_i) begin
                        rem_q   <= '0;
                        fault_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    eject_dollar_q  <= 1'b0;
                    eject_quarter_q <= 1'b0;
                    fault_q         <= 1'b0;
                    busy_q          <= 1'b0;
                    state_q         <= S_IDLE;
                end
            endcase
        end
    end

    assign credit_clr_o    = credit_clr_q;
    assign eject_dollar_o  = eject_dollar_q;
    assign eject_quarter_o = eject_quarter_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign unpaid_o        = unpaid_q;
    assign hopper_empty_o  = hopper_empty_q;
    assign fault_o         = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed testbench for change_dispenser: full/partial refunds, hopper
// exhaustion, refill, ack timeout, asynchronous reset and ignored inputs.
module tb_change_dispenser;

    localparam int PULSE = 4;
    localparam int ACK   = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        refund_req;
    logic [11:0] credit_in;
    logic        coin_sensed;
    logic        refill_dollar;
    logic        refill_quarter;
    logic        fault_clr;
    logic        credit_clr;
    logic        eject_dollar;
    logic        eject_quarter;
    logic        busy;
    logic        done;
    logic [11:0] unpaid;
    logic [1:0]  hopper_empty;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the most recent run_refund call.
    int          r_nd, r_nq, r_nclr, r_clr_i, r_done_i, r_perr, r_ovl, r_lag;
    bit          r_flt, r_tmo;
    logic [11:0] r_unp;

    change_dispenser dut (
        .clk              (clk),
        .rst              (rst),
        .refund_req_i     (refund_req),
        .credit_in_i      (credit_in),
        .coin_sensed_i    (coin_sensed),
        .refill_dollar_i  (refill_dollar),
        .refill_quarter_i (refill_quarter),
        .fault_clr_i      (fault_clr),
        .credit_clr_o     (credit_clr),
        .eject_dollar_o   (eject_dollar),
        .eject_quarter_o  (eject_quarter),
        .busy_o           (busy),
        .done_o           (done),
        .unpaid_o         (unpaid),
        .hopper_empty_o   (hopper_empty),
        .fault_o          (fault)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        refund_req = 1'b0; credit_in = 12'd0; coin_sensed = 1'b0;
        refill_dollar = 1'b0; refill_quarter = 1'b0; fault_clr = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one refund and follow it to done or fault. With echo set, the
    // sensor rises 3 cycles after each eject pulse ends and stays up 2 cycles.
    // With poke set, a fresh request edge and both refills are driven while busy.
    task automatic run_refund(input logic [11:0] credit, input bit echo, input bit poke, input bit refill_d);
        int  fall_i;
        int  run;
        bit  cur_d;
        bit  poked;
        r_nd = 0; r_nq = 0; r_nclr = 0; r_clr_i = -1; r_done_i = -1;
        r_perr = 0; r_ovl = 0; r_lag = -1; r_flt = 1'b0; r_tmo = 1'b1; r_unp = 12'hfff;
        fall_i = -100; run = 0; cur_d = 1'b0; poked = 1'b0;
        @(negedge clk);
        credit_in = credit; refund_req = 1'b1; refill_dollar = refill_d;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (i == 1) begin
                refund_req = 1'b0; refill_dollar = 1'b0;
            end
            if (credit_clr) begin
                r_nclr++;
                if (r_clr_i < 0) r_clr_i = i;
            end
            if (eject_dollar && eject_quarter) r_ovl++;
            if (eject_dollar || eject_quarter) begin
                run++;
                cur_d = eject_dollar;
                if (poke && !poked) begin
                    refund_req = 1'b1; refill_dollar = 1'b1; refill_quarter = 1'b1; poked = 1'b1;
                end
            end else if (run > 0) begin
                if (run != PULSE) r_perr++;
                if (cur_d) r_nd++; else r_nq++;
                run = 0;
                fall_i = i;
            end
            if (echo && (i == fall_i + 3)) coin_sensed = 1'b1;
            if (i == fall_i + 5) coin_sensed = 1'b0;
            if (done) begin
                r_unp = unpaid; r_done_i = i; r_tmo = 1'b0;
                break;
            end
            if (fault) begin
                r_flt = 1'b1; r_lag = i - fall_i; r_unp = unpaid; r_tmo = 1'b0;
                break;
            end
        end
        refund_req = 1'b0; refill_dollar = 1'b0; refill_quarter = 1'b0; coin_sensed = 1'b0;
        if (r_tmo) begin
            n_checks++; n_fail++;
            $display("FAIL refund_bound: no done/fault within 2000 cycles for credit %0d", credit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        refund_req = 1'b0; credit_in = 12'd0; coin_sensed = 1'b0;
        refill_dollar = 1'b0; refill_quarter = 1'b0; fault_clr = 1'b0;
        #1;
        n_checks++; if ({credit_clr, eject_dollar, eject_quarter, busy, done, fault} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {credit_clr, eject_dollar, eject_quarter, busy, done, fault}); end
        n_checks++; if (unpaid !== 12'd0) begin n_fail++; $display("FAIL reset_unpaid: got %0d want 0", unpaid); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (hopper_empty !== 2'b00) begin n_fail++; $display("FAIL reset_empty: got %b want 00", hopper_empty); end
        n_checks++; if (dut.dollars_q !== 6'd20 || dut.quarters_q !== 6'd20) begin n_fail++; $display("FAIL reset_hoppers: got %0d/%0d want 20/20", dut.dollars_q, dut.quarters_q); end
    endtask

    task automatic test_refund_175();
        run_refund(12'd175, 1'b1, 1'b0, 1'b0);
        n_checks++; if (r_nd !== 1 || r_nq !== 3) begin n_fail++; $display("FAIL t175_coins: got %0d$/%0dq want 1/3", r_nd, r_nq); end
        n_checks++; if (r_unp !== 12'd0) begin n_fail++; $display("FAIL t175_unpaid: got %0d want 0", r_unp); end
        n_checks++; if (r_nclr !== 1 || r_clr_i !== 1) begin n_fail++; $display("FAIL t175_credit_clr: got %0d pulses at %0d want 1 at 1", r_nclr, r_clr_i); end
        n_checks++; if (r_perr !== 0 || r_ovl !== 0) begin n_fail++; $display("FAIL t175_pulses: got %0d bad widths %0d overlaps want 0/0", r_perr, r_ovl); end
        n_checks++; if (dut.dollars_q !== 6'd19 || dut.quarters_q !== 6'd17) begin n_fail++; $display("FAIL t175_hoppers: got %0d/%0d want 19/17", dut.dollars_q, dut.quarters_q); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL t175_after: got done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_refund_130();
        run_refund(12'd130, 1'b1, 1'b0, 1'b0);
        n_checks++; if (r_nd !== 1 || r_nq !== 1) begin n_fail++; $display("FAIL t130_coins: got %0d$/%0dq want 1/1", r_nd, r_nq); end
        n_checks++; if (r_unp !== 12'd5) begin n_fail++; $display("FAIL t130_unpaid: got %0d want 5", r_unp); end
        n_checks++; if (dut.dollars_q !== 6'd18 || dut.quarters_q !== 6'd16) begin n_fail++; $display("FAIL t130_hoppers: got %0d/%0d want 18/16", dut.dollars_q, dut.quarters_q); end
    endtask

    task automatic test_zero_credit();
        run_refund(12'd0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (r_done_i !== 1) begin n_fail++; $display("FAIL zero_done_time: got %0d want 1", r_done_i); end
        n_checks++; if (r_nclr !== 0 || r_nd !== 0 || r_nq !== 0) begin n_fail++; $display("FAIL zero_activity: got clr=%0d coins=%0d/%0d want 0/0/0", r_nclr, r_nd, r_nq); end
        n_checks++; if (r_unp !== 12'd0) begin n_fail++; $display("FAIL zero_unpaid: got %0d want 0", r_unp); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", busy); end
    endtask

    task automatic test_busy_ignored();
        run_refund(12'd100, 1'b1, 1'b1, 1'b0);
        n_checks++; if (r_nd !== 1 || r_nq !== 0) begin n_fail++; $display("FAIL busy_coins: got %0d$/%0dq want 1/0", r_nd, r_nq); end
        n_checks++; if (r_nclr !== 1) begin n_fail++; $display("FAIL busy_credit_clr: got %0d want 1", r_nclr); end
        n_checks++; if (dut.dollars_q !== 6'd17 || dut.quarters_q !== 6'd16) begin n_fail++; $display("FAIL busy_refill: got %0d/%0d want 17/16", dut.dollars_q, dut.quarters_q); end
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_requeue: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_eject();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        credit_in = 12'd100; refund_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            refund_req = 1'b0;
            if (eject_dollar) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_eject_start: got no dollar eject want one"); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (eject_dollar !== 1'b0) begin n_fail++; $display("FAIL rst_eject_drop: got %b want 0", eject_dollar); end
        n_checks++; if ({credit_clr, eject_quarter, busy, done, fault, hopper_empty} !== 7'b0 || unpaid !== 12'd0) begin n_fail++; $display("FAIL rst_outputs: got %b unpaid=%0d want 0", {credit_clr, eject_quarter, busy, done, fault, hopper_empty}, unpaid); end
        n_checks++; if (dut.dollars_q !== 6'd20 || dut.quarters_q !== 6'd20) begin n_fail++; $display("FAIL rst_hoppers: got %0d/%0d want 20/20", dut.dollars_q, dut.quarters_q); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || eject_dollar !== 1'b0) begin n_fail++; $display("FAIL rst_lost: got busy=%b eject=%b want 0/0", busy, eject_dollar); end
    endtask

    task automatic test_dollar_empty();
        int tot_d;
        int tot_q;
        tot_d = 0; tot_q = 0;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            run_refund(12'd100, 1'b1, 1'b0, 1'b0);
            tot_d += r_nd; tot_q += r_nq;
        end
        n_checks++; if (tot_d !== 20 || tot_q !== 0) begin n_fail++; $display("FAIL empty_drain: got %0d$/%0dq want 20/0", tot_d, tot_q); end
        run_refund(12'd100, 1'b1, 1'b0, 1'b0);
        n_checks++; if (r_nd !== 0 || r_nq !== 4) begin n_fail++; $display("FAIL empty_coins: got %0d$/%0dq want 0/4", r_nd, r_nq); end
        n_checks++; if (r_unp !== 12'd0) begin n_fail++; $display("FAIL empty_unpaid: got %0d want 0", r_unp); end
        n_checks++; if (hopper_empty !== 2'b10) begin n_fail++; $display("FAIL empty_flag: got %b want 10", hopper_empty); end
    endtask

    task automatic test_refill_same_cycle();
        run_refund(12'd100, 1'b1, 1'b0, 1'b1);
        n_checks++; if (r_nd !== 1 || r_nq !== 0) begin n_fail++; $display("FAIL refill_coins: got %0d$/%0dq want 1/0", r_nd, r_nq); end
        n_checks++; if (dut.dollars_q !== 6'd62) begin n_fail++; $display("FAIL refill_count: got %0d want 62", dut.dollars_q); end
        @(negedge clk);
        n_checks++; if (hopper_empty !== 2'b00) begin n_fail++; $display("FAIL refill_flag: got %b want 00", hopper_empty); end
    endtask

    task automatic test_timeout_fault();
        apply_reset();
        run_refund(12'd100, 1'b0, 1'b0, 1'b0);
        n_checks++; if (r_flt !== 1'b1 || r_lag !== ACK) begin n_fail++; $display("FAIL fault_timing: got fault=%b lag=%0d want 1/%0d", r_flt, r_lag, ACK); end
        n_checks++; if (r_unp !== 12'd100) begin n_fail++; $display("FAIL fault_unpaid: got %0d want 100", r_unp); end
        n_checks++; if (busy !== 1'b1 || eject_dollar !== 1'b0 || eject_quarter !== 1'b0) begin n_fail++; $display("FAIL fault_outputs: got busy=%b ej=%b%b want 1/00", busy, eject_dollar, eject_quarter); end
        repeat (3) @(negedge clk);
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_hold: got %b want 1", fault); end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        n_checks++; if (fault !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got fault=%b busy=%b done=%b want 0/0/0", fault, busy, done); end
        n_checks++; if (dut.dollars_q !== 6'd20) begin n_fail++; $display("FAIL fault_hopper: got %0d want 20", dut.dollars_q); end
    endtask

    initial begin
        test_reset();
        test_refund_175();
        test_refund_130();
        test_zero_credit();
        test_busy_ignored();
        test_reset_mid_eject();
        test_dollar_empty();
        test_refill_same_cycle();
        test_timeout_fault();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
